dout_capture_fifo: RTL and testbench

- Downstream neighbour of the DUT in the scenario benches: samples the DUT's 1-bit serial output and packs it into WIDTH-bit words, LSB first.
- Buffers the packed words in a DEPTH-entry FIFO. The scenario side (via the DPI-C monitor task) drains the FIFO with a request/valid handshake.
- Closes the loop so C scenarios can check DUT output, mirroring how the driver feeds the DUT's input.

---
 rtl/dout_capture_fifo_if.sv | 30 +++
 rtl/dout_capture_fifo.sv | 142 ++++++++++++++
 tb/tb_dout_capture_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dout_capture_fifo_if.sv
// Capture/drain bundle between the serial-output capture FIFO and the scenario side.
// master drives capture and pop requests; slave (the FIFO) returns words and status.
interface dout_capture_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             cap_en;
    logic             din;
    logic             flush;
    logic             rd_req;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [LW-1:0]    level;
    logic             busy;
    logic             ovf;
    logic [CW-1:0]    drop_cnt;

    modport master (
        output cap_en, din, flush, rd_req,
        input  rd_valid, rd_data, level, busy, ovf, drop_cnt
    );

    modport slave (
        input  cap_en, din, flush, rd_req,
        output rd_valid, rd_data, level, busy, ovf, drop_cnt
    );
endinterface

// File: rtl/dout_capture_fifo.sv
// Packs a 1-bit serial stream LSB-first into WIDTH-bit words and buffers them in a
// DEPTH-entry FIFO drained by a request/valid pop; overflowing words are counted.
module dout_capture_fifo #(
    parameter int id    = 1,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    dout_capture_fifo_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // id only labels instances in debug output of the scenario harness
    if (id < 0) begin : g_id_label
    end

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  word_w;
    logic              push_req;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              ovf_q;
    logic [CW-1:0]     drop_cnt_q;

    logic              full_w, empty_w, pop_w, push_ok_w, drop_w;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        word_w    = shift_q;
        word_w[bit_cnt_q] = bus.din;
        if (bus.flush) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (bus.cap_en) begin
            if (bit_cnt_q == LAST_BIT) begin
                // Final bit: word_w already carries this cycle's din
                push_req  = 1'b1;
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                state_d   = S_FILL;
                bit_cnt_d = bit_cnt_q + BW'(1);
                shift_d   = word_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign full_w    = (level_q == FULL_LVL);
    assign empty_w   = (level_q == '0);
    assign pop_w     = bus.rd_req && !empty_w && !bus.flush;
    // A pop on the same edge frees the slot the full-FIFO push needs
    assign push_ok_w = push_req && (!full_w || pop_w);
    assign drop_w    = push_req && full_w && !pop_w;

    always_ff @(posedge clk) begin
        if (push_ok_w) begin
            mem_q[wr_ptr_q] <= word_w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_valid_q <= pop_w;
            if (push_ok_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({push_ok_w, pop_w})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop_w) begin
                ovf_q      <= 1'b1;
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
        end
    end

    assign bus.busy     = (bit_cnt_q != '0);
    assign bus.level    = level_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.ovf      = ovf_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_dout_capture_fifo.sv
// Directed bench for dout_capture_fifo (WIDTH=8, DEPTH=16): capture, pop order,
// overflow/drop, full push-with-pop, async reset mid-word and flush priority.
module tb_dout_capture_fifo;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dout_capture_fifo_if #(.WIDTH(8), .DEPTH(16), .CW(16)) bus ();

    dout_capture_fifo #(.id(1), .WIDTH(8), .DEPTH(16), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_bit(input logic b);
        bus.cap_en = 1'b1;
        bus.din    = b;
        step();
        bus.cap_en = 1'b0;
        bus.din    = 1'b0;
    endtask

    task automatic cap_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) cap_bit(w[i]);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, ".data"}, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] pat;
        bus.cap_en = 1'b0;
        bus.din    = 1'b0;
        bus.flush  = 1'b0;
        bus.rd_req = 1'b0;
        rst        = 1'b0;
        step();
        step();
        chk("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst.rd_data",  32'(bus.rd_data),  32'd0);
        chk("rst.level",    32'(bus.level),    32'd0);
        chk("rst.busy",     32'(bus.busy),     32'd0);
        chk("rst.ovf",      32'(bus.ovf),      32'd0);
        chk("rst.drop_cnt", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b1;
        step();

        // Bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D
        pat = 8'b0100_1101;
        for (int i = 0; i < 4; i++) cap_bit(pat[i]);
        chk("w1.busy_mid", 32'(bus.busy), 32'd1);
        chk("w1.level_mid", 32'(bus.level), 32'd0);
        for (int i = 4; i < 8; i++) cap_bit(pat[i]);
        chk("w1.level", 32'(bus.level), 32'd1);
        chk("w1.busy_end", 32'(bus.busy), 32'd0);
        pop_chk("w1.pop", 8'h4D);
        chk("w1.level_after", 32'(bus.level), 32'd0);
        step();
        chk("w1.valid_drop", 32'(bus.rd_valid), 32'd0);
        chk("w1.data_hold", 32'(bus.rd_data), 32'h4D);

        // cap_en on alternate cycles: partial words hold between samples
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            cap_bit(pat[i]);
            if (i == 3) chk("tog.busy_hold", 32'(bus.busy), 32'd1);
            step();
        end
        chk("tog.busy_between", 32'(bus.busy), 32'd0);
        chk("tog.level1", 32'(bus.level), 32'd1);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            cap_bit(pat[i]);
            step();
            if (i == 2) chk("tog.busy_hold2", 32'(bus.busy), 32'd1);
        end
        chk("tog.level2", 32'(bus.level), 32'd2);
        pop_chk("tog.pop0", 8'hA5);
        pop_chk("tog.pop1", 8'h3C);

        // Overflow: 16 words fill, 2 more dropped
        for (int i = 0; i < 16; i++) cap_word(8'(8'h10 + i));
        chk("ovf.level_full", 32'(bus.level), 32'd16);
        chk("ovf.ovf_clear", 32'(bus.ovf), 32'd0);
        cap_word(8'hE0);
        cap_word(8'hE1);
        chk("ovf.level", 32'(bus.level), 32'd16);
        chk("ovf.ovf", 32'(bus.ovf), 32'd1);
        chk("ovf.drop_cnt", 32'(bus.drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf.pop%0d", i), 8'(8'h10 + i));
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("ovf.empty_valid", 32'(bus.rd_valid), 32'd0);
        chk("ovf.empty_hold", 32'(bus.rd_data), 32'h1F);
        chk("ovf.empty_level", 32'(bus.level), 32'd0);

        // Full FIFO: final bit lands on the same edge as a pop
        for (int i = 0; i < 16; i++) cap_word(8'(8'h40 + i));
        pat = 8'h99;
        for (int i = 0; i < 7; i++) cap_bit(pat[i]);
        bus.cap_en = 1'b1;
        bus.din    = pat[7];
        bus.rd_req = 1'b1;
        step();
        bus.cap_en = 1'b0;
        bus.din    = 1'b0;
        bus.rd_req = 1'b0;
        chk("fpp.valid", 32'(bus.rd_valid), 32'd1);
        chk("fpp.data", 32'(bus.rd_data), 32'h40);
        chk("fpp.level", 32'(bus.level), 32'd16);
        chk("fpp.drop_cnt", 32'(bus.drop_cnt), 32'd2);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("fpp.pop%0d", i), 8'(8'h40 + i));
        pop_chk("fpp.pop_new", 8'h99);
        chk("fpp.level_end", 32'(bus.level), 32'd0);

        // Async reset in the middle of a word
        for (int i = 0; i < 4; i++) cap_bit(1'b1);
        chk("arst.busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.level", 32'(bus.level), 32'd0);
        chk("arst.ovf", 32'(bus.ovf), 32'd0);
        chk("arst.drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("arst.rd_data", 32'(bus.rd_data), 32'd0);
        step();
        rst = 1'b1;
        step();
        cap_word(8'hFF);
        chk("arst.level_ff", 32'(bus.level), 32'd1);
        pop_chk("arst.pop", 8'hFF);

        // Flush wins over a simultaneous capture bit and pop
        for (int i = 0; i < 17; i++) cap_word(8'(8'h60 + i));
        for (int i = 0; i < 13; i++) pop_chk($sformatf("fl.pop%0d", i), 8'(8'h60 + i));
        chk("fl.level3", 32'(bus.level), 32'd3);
        chk("fl.ovf_set", 32'(bus.ovf), 32'd1);
        chk("fl.drop1", 32'(bus.drop_cnt), 32'd1);
        for (int i = 0; i < 5; i++) cap_bit(1'b1);
        bus.flush  = 1'b1;
        bus.rd_req = 1'b1;
        bus.cap_en = 1'b1;
        bus.din    = 1'b1;
        step();
        bus.flush  = 1'b0;
        bus.rd_req = 1'b0;
        bus.cap_en = 1'b0;
        bus.din    = 1'b0;
        chk("fl.level", 32'(bus.level), 32'd0);
        chk("fl.busy", 32'(bus.busy), 32'd0);
        chk("fl.ovf", 32'(bus.ovf), 32'd0);
        chk("fl.drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("fl.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("fl.rd_data_hold", 32'(bus.rd_data), 32'h6C);
        cap_word(8'h5A);
        pop_chk("fl.pop_after", 8'h5A);
        chk("fl.level_end", 32'(bus.level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
